// File: rtl/param_updown_counter.sv
// Parametrised up/down modulo counter with clear, load, terminal-count pulse,
// sticky overflow and optional one-shot stop.
module param_updown_counter #(
  parameter int unsigned     WIDTH       = 8,
  parameter longint unsigned MOD_VALUE   = 256,
  parameter longint unsigned RESET_VALUE = 0,
  parameter bit              ONE_SHOT    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             load_err,
  output logic             done
);

  localparam logic [WIDTH-1:0] TERM_UP  = WIDTH'(MOD_VALUE - 1);
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] RST_CNT  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH:0]   MOD_WIDE = (WIDTH + 1)'(MOD_VALUE);

  logic [1:0]       rst_sync_q;
  logic             active;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             load_err_q, load_err_d;
  logic             done_q, done_d;
  logic             at_term;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] term_dir;

  // Reset release is synchronised; the counter stays idle until both stages are set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign active = rst_sync_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= RST_CNT;
      tc_q       <= 1'b0;
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      tc_q       <= tc_d;
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
      done_q     <= done_d;
    end
  end

  // Next-state: clr > load > en; ovf set takes precedence over ovf_clr.
  always_comb begin
    count_d    = count_q;
    tc_d       = 1'b0;
    ovf_d      = ovf_q;
    load_err_d = 1'b0;
    done_d     = done_q;
    term_dir   = up_dn ? TERM_UP : ZERO;
    at_term    = (count_q == term_dir);
    stepped    = up_dn ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));

    if (active) begin
      if (ovf_clr) ovf_d = 1'b0;
      if (clr) begin
        count_d = ZERO;
        done_d  = 1'b0;
      end else if (load) begin
        done_d = 1'b0;
        if ({1'b0, load_val} >= MOD_WIDE) begin
          count_d    = TERM_UP;
          load_err_d = 1'b1;
        end else begin
          count_d = load_val;
        end
      end else if (en && !done_q) begin
        if (at_term) begin
          tc_d = 1'b1;
          if (ONE_SHOT) begin
            done_d = 1'b1;
          end else begin
            count_d = up_dn ? ZERO : TERM_UP;
            ovf_d   = 1'b1;
          end
        end else begin
          count_d = stepped;
          // One-shot stops on the edge that lands on the terminal value.
          if (ONE_SHOT && (stepped == term_dir)) begin
            tc_d   = 1'b1;
            done_d = 1'b1;
          end
        end
      end
    end
  end

  assign count    = count_q;
  assign tc       = tc_q;
  assign ovf      = ovf_q;
  assign load_err = load_err_q;
  assign done     = done_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed and model-compared bench for param_updown_counter across several
// parameter sets sharing one stimulus bus.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, up_dn = 1'b0, clr = 1'b0, load = 1'b0, ovf_clr = 1'b0;
  logic [7:0] load_val = 8'd0;

  logic [7:0] c10, c4, c256;
  logic [1:0] c2;
  logic tc10, ovf10, le10, dn10;
  logic tc4, ovf4, le4, dn4;
  logic tc2, ovf2, le2, dn2;
  logic tc256, ovf256, le256, dn256;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(8), .MOD_VALUE(10), .RESET_VALUE(0), .ONE_SHOT(1'b0)) u10 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr), .count(c10), .tc(tc10), .ovf(ovf10),
    .load_err(le10), .done(dn10));

  param_updown_counter #(.WIDTH(8), .MOD_VALUE(4), .RESET_VALUE(0), .ONE_SHOT(1'b1)) u4 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr), .count(c4), .tc(tc4), .ovf(ovf4),
    .load_err(le4), .done(dn4));

  param_updown_counter #(.WIDTH(2), .MOD_VALUE(2), .RESET_VALUE(1), .ONE_SHOT(1'b0)) u2 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val[1:0]), .ovf_clr(ovf_clr), .count(c2), .tc(tc2), .ovf(ovf2),
    .load_err(le2), .done(dn2));

  param_updown_counter #(.WIDTH(8), .MOD_VALUE(256), .RESET_VALUE(5), .ONE_SHOT(1'b0)) u256 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr), .count(c256), .tc(tc256), .ovf(ovf256),
    .load_err(le256), .done(dn256));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; up_dn = 1'b0; clr = 1'b0; load = 1'b0; ovf_clr = 1'b0; load_val = 8'd0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    checks++;
    if (c10 !== 8'd0 || c2 !== 2'd1 || c256 !== 8'd5) begin
      failures++;
      $display("FAIL reset_count c10=%0d c2=%0d c256=%0d want 0 1 5", c10, c2, c256);
    end
    checks++;
    if ({tc10, ovf10, le10, dn10, tc4, dn4, ovf256} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want 0", {tc10, ovf10, le10, dn10, tc4, dn4, ovf256});
    end
    tick(); tick();
    #2 reset = 1'b1;
    en = 1'b1; up_dn = 1'b1;
    tick();
    checks++;
    if (c10 !== 8'd0) begin
      failures++;
      $display("FAIL reset_sync_first_edge c10=%0d want 0", c10);
    end
    idle();
    tick(); tick(); tick();
    clr = 1'b1; tick(); clr = 1'b0;
    checks++;
    if (c10 !== 8'd0 || c2 !== 2'd0 || c256 !== 8'd0) begin
      failures++;
      $display("FAIL clr_all c10=%0d c2=%0d c256=%0d want 0", c10, c2, c256);
    end
  endtask

  task automatic test_up_wrap();
    en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (c10 !== 8'(i % 10) || tc10 !== (i == 10) || ovf10 !== (i >= 10)) begin
        failures++;
        $display("FAIL up_wrap step=%0d count=%0d tc=%b ovf=%b want %0d %b %b",
                 i, c10, tc10, ovf10, i % 10, (i == 10), (i >= 10));
      end
    end
    en = 1'b0;
    tick();
    checks++;
    if (c10 !== 8'd2 || tc10 !== 1'b0 || ovf10 !== 1'b1) begin
      failures++;
      $display("FAIL en_low_hold count=%0d tc=%b ovf=%b want 2 0 1", c10, tc10, ovf10);
    end
  endtask

  task automatic test_down_wrap();
    clr = 1'b1; ovf_clr = 1'b1; tick(); clr = 1'b0; ovf_clr = 1'b0;
    checks++;
    if (c10 !== 8'd0 || ovf10 !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clr count=%0d ovf=%b want 0 0", c10, ovf10);
    end
    en = 1'b1; up_dn = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (c10 !== 8'(10 - i) || tc10 !== (i == 1) || ovf10 !== 1'b1) begin
        failures++;
        $display("FAIL down_wrap step=%0d count=%0d tc=%b ovf=%b want %0d %b 1",
                 i, c10, tc10, ovf10, 10 - i, (i == 1));
      end
    end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    checks++;
    if (c10 !== 8'd4 || ovf10 !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clr_no_wrap count=%0d ovf=%b want 4 0", c10, ovf10);
    end
    tick(); tick(); tick(); tick();
    checks++;
    if (c10 !== 8'd0 || ovf10 !== 1'b0) begin
      failures++;
      $display("FAIL down_to_zero count=%0d ovf=%b want 0 0", c10, ovf10);
    end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    checks++;
    if (c10 !== 8'd9 || tc10 !== 1'b1 || ovf10 !== 1'b1) begin
      failures++;
      $display("FAIL wrap_vs_ovf_clr count=%0d tc=%b ovf=%b want 9 1 1", c10, tc10, ovf10);
    end
    idle();
  endtask

  task automatic test_load();
    load = 1'b1; load_val = 8'd15; tick();
    checks++;
    if (c10 !== 8'd9 || le10 !== 1'b1) begin
      failures++;
      $display("FAIL load_clamp count=%0d load_err=%b want 9 1", c10, le10);
    end
    load = 1'b0; tick();
    checks++;
    if (c10 !== 8'd9 || le10 !== 1'b0) begin
      failures++;
      $display("FAIL load_err_pulse count=%0d load_err=%b want 9 0", c10, le10);
    end
    load = 1'b1; load_val = 8'd10; tick();
    checks++;
    if (c10 !== 8'd9 || le10 !== 1'b1) begin
      failures++;
      $display("FAIL load_eq_mod count=%0d load_err=%b want 9 1", c10, le10);
    end
    load_val = 8'd7; tick();
    checks++;
    if (c10 !== 8'd7 || le10 !== 1'b0) begin
      failures++;
      $display("FAIL load_ok count=%0d load_err=%b want 7 0", c10, le10);
    end
    load_val = 8'd3; en = 1'b1; up_dn = 1'b1; tick();
    checks++;
    if (c10 !== 8'd3) begin
      failures++;
      $display("FAIL load_over_en count=%0d want 3", c10);
    end
    load_val = 8'd255; en = 1'b0; tick();
    checks++;
    if (c256 !== 8'd255 || le256 !== 1'b0 || c10 !== 8'd9 || le10 !== 1'b1) begin
      failures++;
      $display("FAIL load_255 c256=%0d le256=%b c10=%0d le10=%b want 255 0 9 1",
               c256, le256, c10, le10);
    end
    clr = 1'b1; load_val = 8'd15; tick();
    checks++;
    if (c10 !== 8'd0 || le10 !== 1'b0) begin
      failures++;
      $display("FAIL clr_over_load count=%0d load_err=%b want 0 0", c10, le10);
    end
    idle();
  endtask

  task automatic test_one_shot();
    int tcs;
    logic [7:0] exp_c;
    tcs = 0;
    clr = 1'b1; tick(); clr = 1'b0;
    en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (tc4 === 1'b1) tcs++;
      exp_c = (i >= 3) ? 8'd3 : 8'(i);
      checks++;
      if (c4 !== exp_c || dn4 !== (i >= 3) || ovf4 !== 1'b0) begin
        failures++;
        $display("FAIL one_shot step=%0d count=%0d done=%b ovf=%b want %0d %b 0",
                 i, c4, dn4, ovf4, exp_c, (i >= 3));
      end
    end
    checks++;
    if (tcs != 1) begin
      failures++;
      $display("FAIL one_shot_tc_pulses got=%0d want 1", tcs);
    end
    checks++;
    if (dn10 !== 1'b0) begin
      failures++;
      $display("FAIL done_tied_low dn10=%b want 0", dn10);
    end
    en = 1'b0; load = 1'b1; load_val = 8'd1; tick(); load = 1'b0;
    checks++;
    if (c4 !== 8'd1 || dn4 !== 1'b0) begin
      failures++;
      $display("FAIL one_shot_reload count=%0d done=%b want 1 0", c4, dn4);
    end
    en = 1'b1; tick();
    checks++;
    if (c4 !== 8'd2 || dn4 !== 1'b0) begin
      failures++;
      $display("FAIL one_shot_resume count=%0d done=%b want 2 0", c4, dn4);
    end
    tick();
    checks++;
    if (c4 !== 8'd3 || dn4 !== 1'b1 || tc4 !== 1'b1) begin
      failures++;
      $display("FAIL one_shot_redone count=%0d done=%b tc=%b want 3 1 1", c4, dn4, tc4);
    end
    idle();
  endtask

  task automatic test_async_reset();
    load = 1'b1; load_val = 8'd6; tick(); load = 1'b0;
    en = 1'b1; up_dn = 1'b1; tick();
    checks++;
    if (c10 !== 8'd7 || c256 !== 8'd7 || ovf10 !== 1'b1 || dn4 !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset c10=%0d c256=%0d ovf10=%b dn4=%b want 7 7 1 1",
               c10, c256, ovf10, dn4);
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (c10 !== 8'd0 || c256 !== 8'd5 || c2 !== 2'd1 || ovf10 !== 1'b0 ||
        tc10 !== 1'b0 || dn4 !== 1'b0) begin
      failures++;
      $display("FAIL async_reset c10=%0d c256=%0d c2=%0d ovf10=%b tc10=%b dn4=%b want 0 5 1 0 0 0",
               c10, c256, c2, ovf10, tc10, dn4);
    end
    idle();
    #2 reset = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic model_step(inout int c, inout bit t, inout bit o, input int m, input int lv);
    t = 1'b0;
    if (ovf_clr) o = 1'b0;
    if (clr) c = 0;
    else if (load) c = (lv >= m) ? m - 1 : lv;
    else if (en) begin
      c = up_dn ? c + 1 : c - 1;
      if (c >= m || c < 0) begin
        c = (c < 0) ? m - 1 : 0;
        t = 1'b1;
        o = 1'b1;
      end
    end
  endtask

  task automatic test_random();
    int mc[3];
    bit mt[3];
    bit mo[3];
    int got_c[3];
    bit got_t[3];
    bit got_o[3];
    int mods[3];
    mods[0] = 2; mods[1] = 10; mods[2] = 256;
    clr = 1'b1; tick(); clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mc[k] = 0; mt[k] = 1'b0; mo[k] = 1'b0;
    end
    for (int i = 0; i < 2000; i++) begin
      en       = ~en;
      up_dn    = ($urandom_range(0, 3) != 0) ? ~up_dn : up_dn;
      load     = ($urandom_range(0, 7) == 0);
      load_val = 8'($urandom_range(0, 255));
      clr      = ($urandom_range(0, 31) == 0);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      model_step(mc[0], mt[0], mo[0], mods[0], int'(load_val[1:0]));
      model_step(mc[1], mt[1], mo[1], mods[1], int'(load_val));
      model_step(mc[2], mt[2], mo[2], mods[2], int'(load_val));
      tick();
      got_c[0] = int'(c2);   got_t[0] = tc2;   got_o[0] = ovf2;
      got_c[1] = int'(c10);  got_t[1] = tc10;  got_o[1] = ovf10;
      got_c[2] = int'(c256); got_t[2] = tc256; got_o[2] = ovf256;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got_c[k] !== mc[k]) begin
          failures++;
          $display("FAIL rand_count mod=%0d cyc=%0d got=%0d want=%0d", mods[k], i, got_c[k], mc[k]);
        end
        checks++;
        if (got_t[k] !== mt[k]) begin
          failures++;
          $display("FAIL rand_tc mod=%0d cyc=%0d got=%b want=%b", mods[k], i, got_t[k], mt[k]);
        end
        checks++;
        if (got_o[k] !== mo[k]) begin
          failures++;
          $display("FAIL rand_ovf mod=%0d cyc=%0d got=%b want=%b", mods[k], i, got_o[k], mo[k]);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_one_shot();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
